// File: rtl/gpu_pkg.sv
// +----------------------------------------------------------------------+
// | gpu_pkg                                                              |
// | Pipeline, fetcher and LSU status encodings shared across the core.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'b000,
    CORE_FETCH   = 3'b001,
    CORE_DECODE  = 3'b010,
    CORE_REQUEST = 3'b011,
    CORE_WAIT    = 3'b100,
    CORE_EXECUTE = 3'b101,
    CORE_UPDATE  = 3'b110,
    CORE_DONE    = 3'b111
  } core_state_e;

  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_e;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_e;

  // An LSU still owes the core a memory result.
  function automatic logic lsu_busy(input logic [1:0] s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_scheduler_if.sv
// +----------------------------------------------------------------------+
// | core_scheduler_if                                                    |
// | Dispatcher/fetcher/LSU side bundle of the per-core scheduler.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface core_scheduler_if #(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8
);
  localparam int TC_BITS = $clog2(THREADS_PER_BLOCK) + 1;

  logic                                       start;
  logic [TC_BITS-1:0]                         thread_count;
  logic                                       decoded_ret;
  logic [2:0]                                 fetcher_state;
  logic [THREADS_PER_BLOCK-1:0][1:0]          lsu_state;
  logic [THREADS_PER_BLOCK-1:0][PC_BITS-1:0]  next_pc;
  logic [2:0]                                 core_state;
  logic [PC_BITS-1:0]                         current_pc;
  logic [THREADS_PER_BLOCK-1:0]               thread_enable;
  logic                                       done;

  modport master (
    output start, thread_count, decoded_ret, fetcher_state, lsu_state, next_pc,
    input  core_state, current_pc, thread_enable, done
  );

  modport slave (
    input  start, thread_count, decoded_ret, fetcher_state, lsu_state, next_pc,
    output core_state, current_pc, thread_enable, done
  );
endinterface

`default_nettype wire

// File: rtl/core_scheduler.sv
// +----------------------------------------------------------------------+
// | core_scheduler                                                       |
// | Steps one block of convergent threads through the core pipeline.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module core_scheduler
  import gpu_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_BITS           = 8
) (
  input  logic              clk,
  input  logic              reset,
  core_scheduler_if.slave   bus
);

  localparam int TC_BITS = $clog2(THREADS_PER_BLOCK) + 1;

  core_state_e                  state_q, state_d;
  logic [PC_BITS-1:0]           pc_q, pc_d;
  logic [THREADS_PER_BLOCK-1:0] en_q, en_d;
  logic [THREADS_PER_BLOCK-1:0] w_mask;
  logic [THREADS_PER_BLOCK-1:0] w_busy_vec;
  logic                         w_busy;

  // Counts above the slot count naturally saturate to all ones.
  for (genvar i = 0; i < THREADS_PER_BLOCK; i++) begin : g_thread
    assign w_mask[i]     = (bus.thread_count > TC_BITS'(i));
    assign w_busy_vec[i] = en_q[i] && lsu_busy(bus.lsu_state[i]);
  end

  assign w_busy = |w_busy_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CORE_IDLE;
      pc_q    <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    en_d    = en_q;
    unique case (state_q)
      CORE_IDLE: begin
        if (bus.start) begin
          en_d    = w_mask;
          state_d = (bus.thread_count == '0) ? CORE_DONE : CORE_FETCH;
        end
      end
      CORE_FETCH: begin
        if (bus.fetcher_state == FETCHER_FETCHED) state_d = CORE_DECODE;
      end
      CORE_DECODE:  state_d = CORE_REQUEST;
      CORE_REQUEST: state_d = CORE_WAIT;
      CORE_WAIT: begin
        if (!w_busy) state_d = CORE_EXECUTE;
      end
      CORE_EXECUTE: state_d = CORE_UPDATE;
      CORE_UPDATE: begin
        if (bus.decoded_ret) begin
          state_d = CORE_DONE;
        end else begin
          // Threads are convergent, so thread 0 speaks for the block.
          pc_d    = bus.next_pc[0];
          state_d = CORE_FETCH;
        end
      end
      CORE_DONE:    state_d = CORE_DONE;
      default:      state_d = CORE_IDLE;
    endcase
  end

  always_comb begin
    bus.core_state    = state_q;
    bus.current_pc    = pc_q;
    bus.thread_enable = en_q;
    bus.done          = (state_q == CORE_DONE);
  end

endmodule

`default_nettype wire

// File: tb/tb_core_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_core_scheduler                                                    |
// | Directed and randomized checks of core_scheduler against a model.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_core_scheduler;

  localparam int T  = 4;
  localparam int PB = 8;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_REQUEST = 3;
  localparam int S_WAIT = 4, S_EXECUTE = 5, S_UPDATE = 6, S_DONE = 7;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_scheduler_if #(.THREADS_PER_BLOCK(T), .PC_BITS(PB)) bus ();

  core_scheduler #(.THREADS_PER_BLOCK(T), .PC_BITS(PB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_st;
  logic [7:0]  m_pc;
  logic [3:0]  m_en;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference: the pipeline as a sequence of phases driven by the rules.
  task automatic model_step();
    bit busy;
    int tc;
    if (reset) begin
      m_st = S_IDLE; m_pc = 8'h00; m_en = 4'h0;
      return;
    end
    case (m_st)
      S_IDLE: if (bus.start) begin
        tc   = int'(bus.thread_count);
        m_en = (tc >= T) ? 4'hF : 4'((1 << tc) - 1);
        m_st = (tc == 0) ? S_DONE : S_FETCH;
      end
      S_FETCH:   if (bus.fetcher_state == 3'b010) m_st = S_DECODE;
      S_WAIT: begin
        busy = 1'b0;
        for (int i = 0; i < T; i++)
          if (m_en[i] && (bus.lsu_state[i] == 2'd1 || bus.lsu_state[i] == 2'd2)) busy = 1'b1;
        if (!busy) m_st = S_EXECUTE;
      end
      S_UPDATE: begin
        if (bus.decoded_ret) m_st = S_DONE;
        else begin
          m_pc = bus.next_pc[0];
          m_st = S_FETCH;
        end
      end
      S_DONE:    m_st = S_DONE;
      default:   m_st = m_st + 1;
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_eq("state",  32'(bus.core_state),    32'(m_st));
    check_eq("pc",     32'(bus.current_pc),    32'(m_pc));
    check_eq("enable", 32'(bus.thread_enable), 32'(m_en));
    check_eq("done",   32'(bus.done),          32'(m_st == S_DONE));
  endtask

  task automatic loop_once(input logic [7:0] pc);
    bus.fetcher_state = 3'b010;
    bus.lsu_state     = '0;
    bus.decoded_ret   = 1'b0;
    bus.next_pc[0]    = pc;
    repeat (6) tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.thread_count = '0; bus.decoded_ret = 1'b0;
    bus.fetcher_state = 3'b000; bus.lsu_state = '0; bus.next_pc = '0;
    m_st = S_IDLE; m_pc = 8'h00; m_en = 4'h0;
    @(negedge clk);
    tick();
    check_eq("reset_state", 32'(bus.core_state), 32'(S_IDLE));

    // Start held through reset release begins a block on the first free edge.
    bus.start = 1'b1; bus.thread_count = 3'd4;
    tick();
    reset = 1'b0;
    tick();
    check_eq("start_thru_reset", 32'(bus.core_state), 32'(S_FETCH));

    // Four-thread non-memory loop, fetch completing on the second FETCH cycle.
    bus.start = 1'b0;
    tick();
    bus.fetcher_state = 3'b010;
    bus.next_pc[0]    = 8'h01;
    repeat (6) tick();
    check_eq("loop_pc", 32'(bus.current_pc), 32'h01);
    check_eq("loop_mask", 32'(bus.thread_enable), 32'hF);

    // PC wraps through the top of its range untouched.
    loop_once(8'hFF);
    check_eq("pc_ff", 32'(bus.current_pc), 32'hFF);
    loop_once(8'h00);
    check_eq("pc_00", 32'(bus.current_pc), 32'h00);

    // Reset in WAIT clears everything on the next edge.
    loop_once(8'h2A);
    tick(); tick();
    bus.lsu_state[2] = 2'd2;
    tick(); tick();
    check_eq("in_wait", 32'(bus.core_state), 32'(S_WAIT));
    reset = 1'b1;
    tick();
    check_eq("rst_pc", 32'(bus.current_pc), 32'h00);
    check_eq("rst_en", 32'(bus.thread_enable), 32'h0);
    reset = 1'b0;

    // Two threads: disabled thread 3 stays busy but is ignored.
    bus.lsu_state = '0;
    bus.lsu_state[3] = 2'd2; bus.lsu_state[1] = 2'd2;
    bus.thread_count = 3'd2; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick(); tick(); tick();
    repeat (4) tick();
    check_eq("wait_held", 32'(bus.core_state), 32'(S_WAIT));
    bus.lsu_state[1] = 2'd3;
    tick();
    check_eq("wait_exit", 32'(bus.core_state), 32'(S_EXECUTE));
    check_eq("mask_two", 32'(bus.thread_enable), 32'h3);

    // RET finishes the block; DONE ignores start.
    bus.decoded_ret = 1'b1;
    tick(); tick();
    check_eq("ret_done", 32'(bus.done), 32'd1);
    for (int i = 0; i < 10; i++) begin
      bus.start = ~bus.start;
      tick();
    end
    check_eq("done_hold", 32'(bus.core_state), 32'(S_DONE));

    // Empty block goes straight to DONE.
    reset = 1'b1;
    tick();
    reset = 1'b0; bus.thread_count = 3'd0; bus.start = 1'b1;
    tick();
    check_eq("empty_done", 32'(bus.done), 32'd1);
    check_eq("empty_mask", 32'(bus.thread_enable), 32'h0);

    for (int n = 0; n < 3000; n++) begin
      reset              = ($urandom % 40) == 0;
      bus.start          = 1'($urandom);
      bus.thread_count   = 3'($urandom % 8);
      bus.decoded_ret    = ($urandom % 3) == 0;
      bus.fetcher_state  = 3'($urandom % 4);
      for (int i = 0; i < T; i++)
        bus.lsu_state[i] = (($urandom % 3) == 0) ? 2'($urandom) : 2'd0;
      bus.next_pc        = 32'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
